// File: rtl/mnist_feat_pkg.sv
// Shared constants and FSM state type for the tiny MNIST featurizer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mnist_feat_pkg;

  localparam int IMG_DIM = 28;  // image is IMG_DIM x IMG_DIM pixels
  localparam int POOL    = 4;   // block edge in pixels
  localparam int GRID    = 7;   // blocks per image edge
  localparam int NFEAT   = 49;  // GRID*GRID feature bits
  localparam int ACC_W   = 12;  // raw block sum width (16*255 = 4080)
  localparam int CNT_W   = 5;   // lit-pixel count width (max 16)

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } feat_state_e;

endpackage

// File: rtl/mnist_feat_row_acc.sv
// One block-row of accumulators, indexed by block column; add_sum is the post-add value.
// Latency: add_sum is combinational; accumulator update lands on the next clock edge.
// Backpressure: none; the caller qualifies add_en with its own handshake.
module mnist_feat_row_acc
  import mnist_feat_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_en,
  input  logic         add_first,
  input  logic [2:0]   add_idx,
  input  logic [W-1:0] add_val,
  output logic [W-1:0] add_sum
);

  logic [W-1:0] acc_q [GRID];
  logic [W-1:0] acc_d [GRID];

  // First pixel of a block restarts the sum, so every block row starts from zero.
  always_comb begin
    add_sum = (add_first ? '0 : acc_q[add_idx]) + add_val;
  end

  // Next-state: clear wins over add.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      for (int i = 0; i < GRID; i++) begin
        acc_d[i] = '0;
      end
    end else if (add_en) begin
      acc_d[add_idx] = add_sum;
    end
  end

  // Accumulator storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GRID; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mnist_tiny_featurizer.sv
// Pools a 28x28 frame into 7x7 4x4-block threshold bits; MNIST_FEAT_PIX_THRESH_EN selects lit-pixel counting.
// Latency: out_valid rises the cycle after the final (784th or pix_last) pixel is accepted.
// Backpressure: pix_ready drops while a result is pending; result held until out_ready.
module mnist_tiny_featurizer
  import mnist_feat_pkg::*;
#(
  parameter int unsigned SUM_THRESH = 2040,
  parameter int unsigned PIX_THRESH = 128,
  parameter int unsigned CNT_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pix_data,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [NFEAT-1:0] out_bits,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

`ifdef MNIST_FEAT_PIX_THRESH_EN
  localparam int AW = CNT_W;
`else
  localparam int AW = ACC_W;
`endif

  localparam logic [ACC_W-1:0] SUM_THR_W = ACC_W'(SUM_THRESH);
  localparam logic [7:0]       PIX_THR_W = 8'(PIX_THRESH);
  localparam logic [CNT_W-1:0] CNT_THR_W = CNT_W'(CNT_THRESH);
  localparam logic [4:0]       POS_MAX   = 5'(IMG_DIM - 1);

  feat_state_e      state_q, state_d;
  logic [4:0]       col_q, col_d;
  logic [4:0]       row_q, row_d;
  logic [NFEAT-1:0] out_bits_q, out_bits_d;
  logic             out_err_q, out_err_d;

  logic             pix_acc;
  logic             acc_clr;
  logic             add_first;
  logic             blk_end;
  logic             frame_end;
  logic [5:0]       feat_idx;
  logic [AW-1:0]    add_val;
  logic [AW-1:0]    add_sum;
  logic             feat_bit;
  logic             unused_cfg;

  assign pix_ready = (state_q == COLLECT);
  assign out_valid = (state_q == DONE);
  assign out_bits  = out_bits_q;
  assign out_err   = out_err_q;

  assign pix_acc   = pix_valid && (state_q == COLLECT);
  assign add_first = (row_q[1:0] == 2'd0) && (col_q[1:0] == 2'd0);
  assign blk_end   = (&row_q[1:0]) && (&col_q[1:0]);
  assign frame_end = (row_q == POS_MAX) && (col_q == POS_MAX);
  assign feat_idx  = 6'(row_q[4:2]) * 6'd7 + 6'(col_q[4:2]);

`ifdef MNIST_FEAT_PIX_THRESH_EN
  assign add_val    = AW'(pix_data >= PIX_THR_W);
  assign feat_bit   = (add_sum >= CNT_THR_W);
  assign unused_cfg = ^SUM_THR_W;
`else
  assign add_val    = AW'(pix_data);
  assign feat_bit   = (add_sum >= SUM_THR_W);
  assign unused_cfg = ^{PIX_THR_W, CNT_THR_W};
`endif

  mnist_feat_row_acc #(
    .W (AW)
  ) u_row_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .add_en    (pix_acc),
    .add_first (add_first),
    .add_idx   (col_q[4:2]),
    .add_val   (add_val),
    .add_sum   (add_sum)
  );

  // Next-state: scan position, feature writes, frame termination and result handoff.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    out_bits_d = out_bits_q;
    out_err_d  = out_err_q;
    acc_clr    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (pix_acc) begin
          if (blk_end) begin
            out_bits_d[feat_idx] = feat_bit;
          end
          if (pix_last || frame_end) begin
            // Clean frame only when pix_last lands exactly on pixel 784.
            state_d   = DONE;
            out_err_d = !(pix_last && frame_end);
          end else if (col_q == POS_MAX) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d    = COLLECT;
          col_d      = '0;
          row_d      = '0;
          out_bits_d = '0;
          out_err_d  = 1'b0;
          acc_clr    = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers with synchronous reset; reset drops any partial frame or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      col_q      <= '0;
      row_q      <= '0;
      out_bits_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      out_bits_q <= out_bits_d;
      out_err_q  <= out_err_d;
    end
  end

endmodule
